// File: rtl/dmem_arb_pkg.sv
// Shared types for the dmem arbiter.
// FSM states, read owner tag and counter sizing.
package dmem_arb_pkg;

   typedef enum logic {
      NORMAL,
      DBG_LOCKED
   } arb_state_t;

   typedef enum logic {
      OWN_CORE,
      OWN_DBG
   } arb_owner_t;

   // Aging counter width; at least one bit even when MAX_WAIT is 0.
   function automatic int cnt_width(input int max_wait);
      return (max_wait < 1) ? 1 : $clog2(max_wait + 1);
   endfunction

endpackage

// File: rtl/dmem_arbiter.sv
// Core/debug arbiter for the single-port synchronous data memory.
// Core has priority, aging lets debug through, a lock holds debug ownership.
module dmem_arbiter
   import dmem_arb_pkg::*;
#(
   parameter int AW       = 10,
   parameter int DW       = 32,
   parameter int MAX_WAIT = 8
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            core_valid,
   output logic            core_ready,
   input  logic            core_we,
   input  logic [AW-1:0]   core_addr,
   input  logic [DW-1:0]   core_wdata,
   input  logic [DW/8-1:0] core_be,
   output logic            core_rvalid,
   output logic [DW-1:0]   core_rdata,
   input  logic            dbg_valid,
   output logic            dbg_ready,
   input  logic            dbg_we,
   input  logic [AW-1:0]   dbg_addr,
   input  logic [DW-1:0]   dbg_wdata,
   input  logic [DW/8-1:0] dbg_be,
   input  logic            dbg_lock,
   output logic            dbg_rvalid,
   output logic [DW-1:0]   dbg_rdata,
   output logic            mem_en,
   output logic            mem_we,
   output logic [AW-1:0]   mem_addr,
   output logic [DW-1:0]   mem_wdata,
   output logic [DW/8-1:0] mem_be,
   input  logic [DW-1:0]   mem_rdata
);

   localparam int CW = cnt_width(MAX_WAIT);
   localparam logic [CW-1:0] WAIT_MAX = CW'(MAX_WAIT);

   arb_state_t state_q, state_d;
   arb_owner_t rd_owner_q, rd_owner_d;
   logic [CW-1:0] wait_cnt_q, wait_cnt_d;
   logic rd_pend_q, rd_pend_d;
   logic [DW-1:0] core_rdata_q, dbg_rdata_q;
   logic grant_core, grant_dbg;

   // Grant selection and next state; no grants while reset is held.
   always_comb begin
      grant_core = 1'b0;
      grant_dbg  = 1'b0;
      state_d    = state_q;
      if (reset) begin
         unique case (state_q)
            NORMAL: begin
               if (core_valid && dbg_valid) begin
                  if (wait_cnt_q == WAIT_MAX) grant_dbg = 1'b1;
                  else grant_core = 1'b1;
               end else begin
                  grant_core = core_valid;
                  grant_dbg  = dbg_valid;
               end
            end
            DBG_LOCKED: grant_dbg = dbg_valid;
         endcase
         if (grant_dbg) state_d = dbg_lock ? DBG_LOCKED : NORMAL;
      end
   end

   // Aging: count stalled debug cycles, saturate, clear on grant or idle.
   always_comb begin
      wait_cnt_d = wait_cnt_q;
      if (!dbg_valid || grant_dbg) wait_cnt_d = '0;
      else if (wait_cnt_q != WAIT_MAX) wait_cnt_d = wait_cnt_q + CW'(1);
   end

   // Route the winner onto the memory port; byte enables only on writes.
   always_comb begin
      mem_en    = 1'b0;
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      mem_be    = '0;
      if (grant_core) begin
         mem_en    = 1'b1;
         mem_we    = core_we;
         mem_addr  = core_addr;
         mem_wdata = core_wdata;
         mem_be    = core_we ? core_be : '0;
      end else if (grant_dbg) begin
         mem_en    = 1'b1;
         mem_we    = dbg_we;
         mem_addr  = dbg_addr;
         mem_wdata = dbg_wdata;
         mem_be    = dbg_we ? dbg_be : '0;
      end
   end

   assign core_ready = grant_core;
   assign dbg_ready  = grant_dbg;
   assign rd_pend_d  = mem_en & ~mem_we;
   assign rd_owner_d = grant_dbg ? OWN_DBG : OWN_CORE;

   assign core_rvalid = rd_pend_q && (rd_owner_q == OWN_CORE);
   assign dbg_rvalid  = rd_pend_q && (rd_owner_q == OWN_DBG);
   assign core_rdata  = core_rvalid ? mem_rdata : core_rdata_q;
   assign dbg_rdata   = dbg_rvalid ? mem_rdata : dbg_rdata_q;

   // State, aging counter, read tracking and held read data.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q      <= NORMAL;
         wait_cnt_q   <= '0;
         rd_pend_q    <= 1'b0;
         rd_owner_q   <= OWN_CORE;
         core_rdata_q <= '0;
         dbg_rdata_q  <= '0;
      end else begin
         state_q    <= state_d;
         wait_cnt_q <= wait_cnt_d;
         rd_pend_q  <= rd_pend_d;
         rd_owner_q <= rd_owner_d;
         if (core_rvalid) core_rdata_q <= mem_rdata;
         if (dbg_rvalid) dbg_rdata_q <= mem_rdata;
      end
   end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Testbench for dmem_arbiter: vector table plus read-response scoreboard.
// Includes a behavioural single-port memory with one-cycle read latency.
module tb_dmem_arbiter;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        core_valid, core_ready, core_we, core_rvalid;
   logic [9:0]  core_addr;
   logic [31:0] core_wdata, core_rdata;
   logic [3:0]  core_be;
   logic        dbg_valid, dbg_ready, dbg_we, dbg_lock, dbg_rvalid;
   logic [9:0]  dbg_addr;
   logic [31:0] dbg_wdata, dbg_rdata;
   logic [3:0]  dbg_be;
   logic        mem_en, mem_we;
   logic [9:0]  mem_addr;
   logic [31:0] mem_wdata;
   logic [3:0]  mem_be;
   logic [31:0] mem_rdata = '0;

   always #5 clk = ~clk;

   dmem_arbiter #(.AW(10), .DW(32), .MAX_WAIT(8)) dut (
      .clk(clk), .reset(reset),
      .core_valid(core_valid), .core_ready(core_ready),
      .core_we(core_we), .core_addr(core_addr),
      .core_wdata(core_wdata), .core_be(core_be),
      .core_rvalid(core_rvalid), .core_rdata(core_rdata),
      .dbg_valid(dbg_valid), .dbg_ready(dbg_ready),
      .dbg_we(dbg_we), .dbg_addr(dbg_addr),
      .dbg_wdata(dbg_wdata), .dbg_be(dbg_be), .dbg_lock(dbg_lock),
      .dbg_rvalid(dbg_rvalid), .dbg_rdata(dbg_rdata),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_be(mem_be), .mem_rdata(mem_rdata)
   );

   // Memory array: preloaded on the first edge, then serves the port.
   logic [31:0] mem [1024];
   logic        mem_init_q = 1'b0;
   always @(posedge clk) begin
      if (!mem_init_q) begin
         for (int i = 0; i < 1024; i++) mem[i] <= '0;
         mem[10'h004] <= 32'hDEADBEEF;
         mem[10'h030] <= 32'hCAFEF00D;
         mem_init_q <= 1'b1;
      end else if (mem_en) begin
         if (mem_we) begin
            for (int b = 0; b < 4; b++)
               if (mem_be[b]) mem[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
         end else begin
            mem_rdata <= mem[mem_addr];
         end
      end
   end

   typedef struct {
      logic        cv, cwe;
      logic [9:0]  ca;
      logic [31:0] cd;
      logic [3:0]  cb;
      logic        dv, dwe;
      logic [9:0]  da;
      logic [31:0] dd;
      logic [3:0]  db;
      logic        dl;
      logic        ecr, edr;
   } vec_t;

   typedef struct {
      logic        own;
      logic [31:0] data;
      int          due;
   } rsp_t;

   rsp_t        sb[$];
   rsp_t        r;
   vec_t        tbl[$];
   logic [31:0] ref_mem [1024];
   logic [31:0] last_c = '0, last_d = '0;
   int          cyc = 0;
   int          n_chk = 0, n_fail = 0;
   bit          mon_en = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   function automatic vec_t mk(
      input logic cv, input logic cwe, input logic [9:0] ca,
      input logic [31:0] cd, input logic [3:0] cb,
      input logic dv, input logic dwe, input logic [9:0] da,
      input logic [31:0] dd, input logic [3:0] db, input logic dl,
      input logic ecr, input logic edr);
      vec_t v;
      v.cv = cv; v.cwe = cwe; v.ca = ca; v.cd = cd; v.cb = cb;
      v.dv = dv; v.dwe = dwe; v.da = da; v.dd = dd; v.db = db;
      v.dl = dl; v.ecr = ecr; v.edr = edr;
      return v;
   endfunction

   task automatic drive(input vec_t v);
      core_valid = v.cv; core_we = v.cwe; core_addr = v.ca;
      core_wdata = v.cd; core_be = v.cb;
      dbg_valid = v.dv; dbg_we = v.dwe; dbg_addr = v.da;
      dbg_wdata = v.dd; dbg_be = v.db; dbg_lock = v.dl;
   endtask

   // One cycle: apply a vector, check grants and the memory port,
   // update the reference memory and queue the expected read response.
   task automatic step(input vec_t v, input bit rsp);
      logic        ewe;
      logic [9:0]  ea;
      logic [31:0] ed;
      logic [3:0]  eb;
      @(negedge clk);
      drive(v);
      #1;
      chk("core_ready", core_ready, v.ecr);
      chk("dbg_ready", dbg_ready, v.edr);
      chk("mem_en", mem_en, v.ecr | v.edr);
      if (v.ecr | v.edr) begin
         ewe = v.ecr ? v.cwe : v.dwe;
         ea  = v.ecr ? v.ca : v.da;
         ed  = v.ecr ? v.cd : v.dd;
         eb  = v.ecr ? v.cb : v.db;
         chk("mem_we", mem_we, ewe);
         chk("mem_addr", mem_addr, ea);
         if (ewe) begin
            chk("mem_wdata", mem_wdata, ed);
            chk("mem_be", mem_be, eb);
            for (int b = 0; b < 4; b++)
               if (eb[b]) ref_mem[ea][8*b +: 8] = ed[8*b +: 8];
         end else begin
            chk("mem_be_rd", mem_be, 0);
            if (rsp) sb.push_back('{own: v.edr, data: ref_mem[ea], due: cyc + 1});
         end
      end else begin
         chk("mem_we_idle", mem_we, 0);
      end
   endtask

   // Response monitor: pops the scoreboard whenever a read returns.
   always @(negedge clk) begin
      #2;
      if (mon_en) begin
         if (core_rvalid || dbg_rvalid) begin
            if (sb.size() == 0) begin
               chk("rvalid_unexp", {core_rvalid, dbg_rvalid}, 0);
            end else begin
               r = sb.pop_front();
               chk("rsp_cycle", cyc, r.due);
               chk("core_rvalid", core_rvalid, !r.own);
               chk("dbg_rvalid", dbg_rvalid, r.own);
               if (r.own) begin
                  chk("dbg_rdata", dbg_rdata, r.data);
                  chk("core_rdata_held", core_rdata, last_c);
                  last_d = r.data;
               end else begin
                  chk("core_rdata", core_rdata, r.data);
                  chk("dbg_rdata_held", dbg_rdata, last_d);
                  last_c = r.data;
               end
            end
         end else begin
            if (sb.size() != 0 && sb[0].due <= cyc) begin
               chk("rsp_missing", {core_rvalid, dbg_rvalid},
                   sb[0].own ? 32'd1 : 32'd2);
               void'(sb.pop_front());
            end
            chk("core_rdata_idle", core_rdata, last_c);
            chk("dbg_rdata_idle", dbg_rdata, last_d);
         end
      end
   end

   task automatic chk_all_zero(input string tag);
      chk({tag, "_core_ready"}, core_ready, 0);
      chk({tag, "_dbg_ready"}, dbg_ready, 0);
      chk({tag, "_rvalid"}, {core_rvalid, dbg_rvalid}, 0);
      chk({tag, "_core_rdata"}, core_rdata, 0);
      chk({tag, "_dbg_rdata"}, dbg_rdata, 0);
      chk({tag, "_mem_en_we"}, {mem_en, mem_we}, 0);
      chk({tag, "_mem_addr"}, mem_addr, 0);
      chk({tag, "_mem_wdata"}, mem_wdata, 0);
      chk({tag, "_mem_be"}, mem_be, 0);
   endtask

   vec_t idle;

   initial begin
      for (int i = 0; i < 1024; i++) ref_mem[i] = '0;
      ref_mem[10'h004] = 32'hDEADBEEF;
      ref_mem[10'h030] = 32'hCAFEF00D;
      idle = mk(0,0,0,0,0, 0,0,0,0,0,0, 0,0);

      // single core read
      tbl.push_back(mk(1,0,10'h004,0,0, 0,0,0,0,0,0, 1,0));
      tbl.push_back(idle);
      // partial byte write then readback
      tbl.push_back(mk(1,1,10'h020,32'h0000AB00,4'b0010, 0,0,0,0,0,0, 1,0));
      tbl.push_back(mk(1,0,10'h020,0,0, 0,0,0,0,0,0, 1,0));
      tbl.push_back(idle);
      // debug lock: write locked, idle locked, read unlocks, core resumes
      tbl.push_back(mk(0,0,0,0,0, 1,1,10'h010,32'h11223344,4'hF,1, 0,1));
      tbl.push_back(mk(1,0,10'h030,0,0, 0,0,0,0,0,0, 0,0));
      tbl.push_back(mk(1,0,10'h030,0,0, 1,0,10'h010,0,0,0, 0,1));
      tbl.push_back(mk(1,0,10'h030,0,0, 0,0,0,0,0,0, 1,0));
      tbl.push_back(idle);
      // interleaved reads from both masters
      tbl.push_back(mk(1,0,10'h004,0,0, 0,0,0,0,0,0, 1,0));
      tbl.push_back(mk(0,0,0,0,0, 1,0,10'h020,0,0,0, 0,1));
      tbl.push_back(idle);
      tbl.push_back(idle);
      // aging: debug overrides core on the ninth contended cycle
      for (int i = 1; i <= 10; i++)
         tbl.push_back(mk(1,0,10'h030,0,0, 1,0,10'h010,0,0,0,
                          (i != 9), (i == 9)));
      tbl.push_back(idle);
      tbl.push_back(idle);

      // reset: outputs quiet even with requests present
      drive(idle);
      repeat (2) @(negedge clk);
      core_valid = 1'b1;
      dbg_valid  = 1'b1;
      #1;
      chk_all_zero("por");
      drive(idle);
      @(negedge clk);
      reset = 1'b1;
      mon_en = 1'b1;

      foreach (tbl[i]) step(tbl[i], 1'b1);

      // reset in the cycle after a read grant drops the response
      step(mk(1,0,10'h030,0,0, 0,0,0,0,0,0, 1,0), 1'b0);
      @(posedge clk);
      #1;
      reset = 1'b0;
      last_c = '0;
      last_d = '0;
      @(negedge clk);
      #1;
      chk_all_zero("rst_rd");
      drive(idle);
      reset = 1'b1;

      // reset while locked returns to normal arbitration
      step(mk(0,0,0,0,0, 1,1,10'h040,32'h55AA55AA,4'hF,1, 0,1), 1'b1);
      @(posedge clk);
      #1;
      reset = 1'b0;
      @(negedge clk);
      core_valid = 1'b1;
      dbg_valid  = 1'b1;
      dbg_lock   = 1'b1;
      #1;
      chk_all_zero("rst_lock");
      drive(idle);
      reset = 1'b1;
      step(mk(1,0,10'h040,0,0, 0,0,0,0,0,0, 1,0), 1'b1);
      step(idle, 1'b1);
      step(idle, 1'b1);

      chk("sb_drained", sb.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
